// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch resolver, load/branch hazard stall FSM and perf counters
module branch_hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int BR_EX_STALL = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_is_jal,
    input  logic              id_is_jalr,
    input  logic [2:0]        id_funct3,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              fetch_write,
    output logic              bubble,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_if,
    output logic              illegal_br,
    output logic              stall,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NW = $clog2(LOAD_LAT + 2);
    localparam logic [NW-1:0] N_ONE     = NW'(1);
    localparam logic [NW-1:0] N_LOAD    = NW'(LOAD_LAT);
    localparam logic [NW-1:0] N_LOAD_BR = NW'(LOAD_LAT + 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t            state_q;
    logic [NW-1:0]     cnt_q;
    logic [NW-1:0]     need_n;
    logic [XLEN-1:0]   op1, op2;
    logic              ex_hit, mem_hit, br_like;
    logic              stall_c, resolve, cond, taken;
    logic [XLEN-1:0]   jalr_sum, target;
    logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q, stall_cnt_q;
    logic [CNT_W-1:0]  br_cnt_d, taken_cnt_d, stall_cnt_d;

    // MEM forwarding wins over WB; a load in MEM has no data yet so it cannot forward
    always_comb begin
        op1 = rf_data1;
        if (id_rs1 == '0)
            op1 = '0;
        else if (mem_reg_write && !mem_mem_read && mem_rd == id_rs1)
            op1 = mem_data;
        else if (wb_reg_write && wb_rd == id_rs1)
            op1 = wb_data;
        op2 = rf_data2;
        if (id_rs2 == '0)
            op2 = '0;
        else if (mem_reg_write && !mem_mem_read && mem_rd == id_rs2)
            op2 = mem_data;
        else if (wb_reg_write && wb_rd == id_rs2)
            op2 = wb_data;
    end

    assign ex_hit  = (ex_rd != '0) && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign mem_hit = (mem_rd != '0) && ((id_use_rs1 && id_rs1 == mem_rd) || (id_use_rs2 && id_rs2 == mem_rd));
    assign br_like = id_is_branch || id_is_jalr;

    // Branch terms are ordered so the first match is also the largest stall
    always_comb begin
        need_n = '0;
        if (id_valid) begin
            if (br_like && ex_mem_read && ex_hit)
                need_n = N_LOAD_BR;
            else if (ex_mem_read && ex_hit)
                need_n = N_LOAD;
            else if (br_like && (((BR_EX_STALL != 0) && ex_reg_write && ex_hit) || (mem_mem_read && mem_hit)))
                need_n = N_ONE;
        end
    end

    assign stall_c = !rst && (state_q == HOLD || need_n != '0);
    assign resolve = !rst && id_valid && !stall_c;

    always_comb begin
        cond = 1'b0;
        case (id_funct3)
            3'b000:  cond = (op1 == op2);
            3'b001:  cond = (op1 != op2);
            3'b100:  cond = ($signed(op1) < $signed(op2));
            3'b101:  cond = ($signed(op1) >= $signed(op2));
            3'b110:  cond = (op1 < op2);
            3'b111:  cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

    assign taken    = resolve && ((id_is_branch && cond) || id_is_jal || id_is_jalr);
    assign jalr_sum = op1 + id_imm;
    assign target   = id_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc + id_imm);

    assign pc_write    = !stall_c;
    assign fetch_write = !stall_c;
    assign bubble      = stall_c;
    assign stall       = stall_c;
    assign redirect    = taken;
    assign flush_if    = taken;
    assign redirect_pc = rst ? '0 : target;
    assign illegal_br  = resolve && id_is_branch && (id_funct3[2:1] == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (need_n > N_ONE) begin
                        state_q <= HOLD;
                        cnt_q   <= need_n - N_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_q == N_ONE)
                        state_q <= RUN;
                    cnt_q <= cnt_q - N_ONE;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic ev, input logic clr);
        if (clr)
            return '0;
        if (ev && !(&c))
            return c + CNT_W'(1);
        return c;
    endfunction

    assign br_cnt_d    = bump(br_cnt_q, resolve && id_is_branch, perf_clr);
    assign taken_cnt_d = bump(taken_cnt_q, taken, perf_clr);
    assign stall_cnt_d = bump(stall_cnt_q, stall_c, perf_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - scoreboard bench for branch_hazard_ctrl with a reference model
module tb_branch_hazard_ctrl;

    localparam int LL    = 2;
    localparam int BREX  = 1;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic        rst;
        logic        id_valid, is_branch, is_jal, is_jalr;
        logic [2:0]  funct3;
        logic        use1, use2;
        logic [4:0]  rs1, rs2;
        logic [31:0] pc, imm, rf1, rf2;
        logic [4:0]  ex_rd;
        logic        ex_rw, ex_mr;
        logic [4:0]  mem_rd;
        logic        mem_rw, mem_mr;
        logic [31:0] mem_data;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_data;
        logic        perf_clr;
    } stim_t;

    typedef struct {
        logic        pc_write, redirect, illegal;
        logic [31:0] rpc;
        int          br, tk, st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_is_branch, id_is_jal, id_is_jalr, id_use_rs1, id_use_rs2;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic [31:0] id_pc, id_imm, rf_data1, rf_data2, mem_data, wb_data;
    logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write, perf_clr;
    logic pc_write, fetch_write, bubble, redirect, flush_if, illegal_br, stall;
    logic [31:0] redirect_pc;
    logic [CW-1:0] br_cnt, taken_cnt, stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];
    int m_rem = 0, m_br = 0, m_tk = 0, m_st = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(LL), .BR_EX_STALL(BREX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
        .id_is_jalr(id_is_jalr), .id_funct3(id_funct3), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc), .id_imm(id_imm), .rf_data1(rf_data1),
        .rf_data2(rf_data2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data), .perf_clr(perf_clr),
        .pc_write(pc_write), .fetch_write(fetch_write), .bubble(bubble), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush_if(flush_if), .illegal_br(illegal_br), .stall(stall),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    function automatic stim_t base();
        stim_t s;
        s.rst = 0; s.id_valid = 1; s.is_branch = 0; s.is_jal = 0; s.is_jalr = 0; s.funct3 = 0;
        s.use1 = 0; s.use2 = 0; s.rs1 = 0; s.rs2 = 0; s.pc = 0; s.imm = 0; s.rf1 = 0; s.rf2 = 0;
        s.ex_rd = 0; s.ex_rw = 0; s.ex_mr = 0; s.mem_rd = 0; s.mem_rw = 0; s.mem_mr = 0; s.mem_data = 0;
        s.wb_rd = 0; s.wb_rw = 0; s.wb_data = 0; s.perf_clr = 0;
        return s;
    endfunction

    function automatic logic [31:0] operand(stim_t s, logic [4:0] rs, logic [31:0] rf);
        if (rs == 0) return 0;
        if (s.mem_rw && !s.mem_mr && s.mem_rd == rs) return s.mem_data;
        if (s.wb_rw && s.wb_rd == rs) return s.wb_data;
        return rf;
    endfunction

    function automatic bit reads(stim_t s, logic [4:0] rd);
        return rd != 0 && ((s.use1 && s.rs1 == rd) || (s.use2 && s.rs2 == rd));
    endfunction

    function automatic int need(stim_t s);
        int n = 0;
        bit br = s.is_branch || s.is_jalr;
        if (!s.id_valid) return 0;
        if (s.ex_mr && reads(s, s.ex_rd)) n = (n > LL) ? n : LL;
        if (br && s.ex_mr && reads(s, s.ex_rd)) n = (n > LL + 1) ? n : LL + 1;
        if (br && BREX != 0 && s.ex_rw && !s.ex_mr && reads(s, s.ex_rd)) n = (n > 1) ? n : 1;
        if (br && s.mem_mr && reads(s, s.mem_rd)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    function automatic bit br_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    task automatic apply(stim_t s);
        rst = s.rst; id_valid = s.id_valid; id_is_branch = s.is_branch; id_is_jal = s.is_jal;
        id_is_jalr = s.is_jalr; id_funct3 = s.funct3; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_pc = s.pc; id_imm = s.imm; rf_data1 = s.rf1; rf_data2 = s.rf2;
        ex_rd = s.ex_rd; ex_reg_write = s.ex_rw; ex_mem_read = s.ex_mr; mem_rd = s.mem_rd;
        mem_reg_write = s.mem_rw; mem_mem_read = s.mem_mr; mem_data = s.mem_data; wb_rd = s.wb_rd;
        wb_reg_write = s.wb_rw; wb_data = s.wb_data; perf_clr = s.perf_clr;
    endtask

    // One clock of stimulus: predict the outputs, queue them, advance the model
    task automatic step(stim_t s);
        exp_t e;
        int n;
        bit stl, res, tk;
        logic [31:0] a, b;
        @(posedge clk);
        #1;
        apply(s);
        if (s.rst) begin
            m_rem = 0; m_br = 0; m_tk = 0; m_st = 0;
            e.pc_write = 1; e.redirect = 0; e.illegal = 0; e.rpc = 0; e.br = 0; e.tk = 0; e.st = 0;
        end else begin
            a = operand(s, s.rs1, s.rf1);
            b = operand(s, s.rs2, s.rf2);
            n = need(s);
            stl = (m_rem > 0) || (n > 0);
            res = s.id_valid && !stl;
            tk = res && ((s.is_branch && br_taken(s.funct3, a, b)) || s.is_jal || s.is_jalr);
            e.pc_write = !stl;
            e.redirect = tk;
            e.illegal = res && s.is_branch && (s.funct3 == 3'd2 || s.funct3 == 3'd3);
            e.rpc = s.is_jalr ? ((a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
            e.br = m_br; e.tk = m_tk; e.st = m_st;
            if (m_rem > 0) m_rem--;
            else if (n > 1) m_rem = n - 1;
            if (s.perf_clr) begin
                m_br = 0; m_tk = 0; m_st = 0;
            end else begin
                if (res && s.is_branch && m_br < CMAX) m_br++;
                if (tk && m_tk < CMAX) m_tk++;
                if (stl && m_st < CMAX) m_st++;
            end
        end
        q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_write", 32'(pc_write), 32'(e.pc_write));
            chk("fetch_write", 32'(fetch_write), 32'(e.pc_write));
            chk("bubble", 32'(bubble), 32'(!e.pc_write));
            chk("stall", 32'(stall), 32'(!e.pc_write));
            chk("redirect", 32'(redirect), 32'(e.redirect));
            chk("flush_if", 32'(flush_if), 32'(e.redirect));
            chk("illegal_br", 32'(illegal_br), 32'(e.illegal));
            if (e.redirect || !e.pc_write || rst) chk("redirect_pc", redirect_pc, rst ? 32'h0 : (e.redirect ? e.rpc : redirect_pc));
            chk("br_cnt", 32'(br_cnt), 32'(e.br));
            chk("taken_cnt", 32'(taken_cnt), 32'(e.tk));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.st));
        end
    end

    function automatic logic [31:0] rdata();
        case ($urandom_range(0, 3))
            0: return 32'(0);
            1: return 32'($urandom_range(0, 3));
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = base();
        int k = $urandom_range(0, 3);
        s.id_valid = ($urandom_range(0, 7) != 0);
        s.is_branch = (k == 0); s.is_jal = (k == 1); s.is_jalr = (k == 2);
        s.funct3 = 3'($urandom_range(0, 7));
        s.use1 = (k != 1); s.use2 = (k == 0 || (k == 3 && $urandom_range(0, 1) == 1));
        s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
        s.pc = $urandom; s.imm = $urandom; s.rf1 = rdata(); s.rf2 = rdata();
        s.ex_rd = 5'($urandom_range(0, 3)); s.ex_rw = 1'($urandom); s.ex_mr = ($urandom_range(0, 3) == 0);
        s.mem_rd = 5'($urandom_range(0, 3)); s.mem_rw = 1'($urandom); s.mem_mr = ($urandom_range(0, 3) == 0);
        s.mem_data = rdata();
        s.wb_rd = 5'($urandom_range(0, 3)); s.wb_rw = 1'($urandom); s.wb_data = rdata();
        s.perf_clr = ($urandom_range(0, 31) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        int guard;
        s = base();
        s.rst = 1;
        apply(s);
        step(s);
        step(s);

        // load in EX feeding an ALU op: LOAD_LAT stall cycles, then clear
        s = base(); s.use1 = 1; s.rs1 = 5; s.ex_rd = 5; s.ex_rw = 1; s.ex_mr = 1;
        step(s); step(s);
        s = base(); s.use1 = 1; s.rs1 = 5;
        step(s);

        // BEQ with MEM-forwarded x1=7 and WB-forwarded x2=7 (rf x2=3)
        s = base(); s.is_branch = 1; s.funct3 = 0; s.use1 = 1; s.use2 = 1; s.rs1 = 1; s.rs2 = 2;
        s.pc = 32'h100; s.imm = 32'h20; s.rf1 = 0; s.rf2 = 3;
        s.mem_rd = 1; s.mem_rw = 1; s.mem_data = 7; s.wb_rd = 2; s.wb_rw = 1; s.wb_data = 7;
        step(s);

        // BLT vs BLTU on the same operands
        s = base(); s.is_branch = 1; s.funct3 = 3'd4; s.use1 = 1; s.use2 = 1; s.rs1 = 1; s.rs2 = 2;
        s.pc = 32'h200; s.imm = 32'h40; s.rf1 = 32'hFFFF_FFFF; s.rf2 = 1;
        step(s);
        s.funct3 = 3'd6;
        step(s);

        // JALR with both MEM and WB matching rs1
        s = base(); s.is_jalr = 1; s.use1 = 1; s.rs1 = 3; s.imm = 4; s.rf1 = 32'h55;
        s.mem_rd = 3; s.mem_rw = 1; s.mem_data = 32'h1003; s.wb_rd = 3; s.wb_rw = 1; s.wb_data = 32'h9999;
        step(s);

        // branch on a load in EX, then reset in the middle of the stall
        s = base(); s.is_branch = 1; s.use1 = 1; s.rs1 = 6; s.ex_rd = 6; s.ex_rw = 1; s.ex_mr = 1;
        step(s);
        s.rst = 1;
        step(s);
        s = base();
        step(s);

        // illegal funct3
        s = base(); s.is_branch = 1; s.funct3 = 3'd2; s.use1 = 1; s.use2 = 1; s.rs1 = 1; s.rs2 = 1;
        step(s);

        // drive stall_cnt into saturation, then clear while a stall is still happening
        s = base(); s.use1 = 1; s.rs1 = 5; s.ex_rd = 5; s.ex_rw = 1; s.ex_mr = 1;
        repeat (CMAX + 20) step(s);
        s.perf_clr = 1;
        step(s);
        s.perf_clr = 0;
        step(s);
        s = base();
        step(s);

        repeat (600) step(rand_stim());
        s = base();
        step(s);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
